// File: rtl/load_align_pkg.sv
// Shared types and helpers for the load alignment unit: FSM states, RISC-V
// load funct3 encodings and access-size decode.
package load_align_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4
    } state_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    // Access size in bytes (1, 2, 4 or 8) from the low two funct3 bits.
    function automatic logic [3:0] size_from_funct3(input logic [2:0] funct3);
        logic [3:0] size;
        case (funct3[1:0])
            2'b00:   size = 4'd1;
            2'b01:   size = 4'd2;
            2'b10:   size = 4'd4;
            2'b11:   size = 4'd8;
            default: size = 4'd1;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational byte selection and sign/zero extension of a load result out of
// the two-beat window {beat2, beat1}.
module load_extract
    import load_align_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0]          data,
    input  logic [$clog2(XLEN/8)-1:0]  offset,
    input  logic [2:0]                 funct3,
    output logic [XLEN-1:0]            result
);

    logic [XLEN-1:0] low_s;
    logic [XLEN-1:0] mask_s;
    logic            sign_s;

    // Shift the addressed byte down to bit 0, then keep the access width and fill above it.
    always_comb begin
        low_s  = XLEN'(data >> {offset, 3'b000});
        mask_s = '1;
        sign_s = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                mask_s = XLEN'(8'hFF);
                sign_s = low_s[7];
            end
            2'b01: begin
                mask_s = XLEN'(16'hFFFF);
                sign_s = low_s[15];
            end
            2'b10: begin
                mask_s = XLEN'(32'hFFFF_FFFF);
                sign_s = low_s[31];
            end
            default: begin
                mask_s = '1;
                sign_s = low_s[XLEN-1];
            end
        endcase
        result = (low_s & mask_s) | ({XLEN{sign_s & ~funct3[2]}} & ~mask_s);
    end

endmodule

// File: rtl/load_align_unit.sv
// Load alignment unit: turns a byte-addressed RISC-V load into one or two
// aligned memory beats and returns the extracted, extended result.
module load_align_unit
    import load_align_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [2:0]      req_funct3_i,
    input  logic            flush_i,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            rsp_valid_o,
    output logic [XLEN-1:0] rsp_data_o,
    output logic            rsp_exc_o
);

    localparam int BYTES = XLEN / 8;
    localparam int OFFW  = $clog2(BYTES);

    state_e            state_r;
    logic              ready_r;
    logic              mem_req_r;
    logic              rsp_valid_r;
    logic              rsp_exc_r;
    logic [XLEN-1:0]   mem_addr_r;
    logic [XLEN-1:0]   beat1_r;
    logic [XLEN-1:0]   rsp_data_r;
    logic [OFFW-1:0]   offset_r;
    logic [2:0]        funct3_r;
    logic              two_beat_r;
    logic              second_r;

    logic [OFFW-1:0]   req_off_s;
    logic [3:0]        size_s;
    logic              misaligned_s;
    logic              illegal_s;
    logic              two_beat_s;
    logic [2*XLEN-1:0] merge_s;
    logic [XLEN-1:0]   extract_s;

    // Classify the incoming request: legality, alignment and beat count.
    always_comb begin
        req_off_s    = req_addr_i[OFFW-1:0];
        size_s       = size_from_funct3(req_funct3_i);
        misaligned_s = (req_addr_i[2:0] & 3'(size_s - 4'd1)) != 3'd0;
        illegal_s    = (req_funct3_i == 3'b111)
                     || ((XLEN == 32) && ((req_funct3_i == LD) || (req_funct3_i == LWU)))
                     || ((ALLOW_MISALIGNED == 0) && misaligned_s);
        two_beat_s   = (5'(req_off_s) + 5'(size_s)) > 5'(BYTES);
    end

    // Build the extraction window; single-beat loads only look at the current beat.
    always_comb begin
        if (two_beat_r) begin
            merge_s = {mem_rdata_i, beat1_r};
        end else begin
            merge_s = {{XLEN{1'b0}}, mem_rdata_i};
        end
    end

    load_extract #(
        .XLEN (XLEN)
    ) u_extract (
        .data   (merge_s),
        .offset (offset_r),
        .funct3 (funct3_r),
        .result (extract_s)
    );

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ready_r     <= 1'b1;
            mem_req_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_exc_r   <= 1'b0;
            mem_addr_r  <= '0;
            beat1_r     <= '0;
            rsp_data_r  <= '0;
            offset_r    <= '0;
            funct3_r    <= 3'b000;
            two_beat_r  <= 1'b0;
            second_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid_i) begin
                        ready_r <= 1'b0;
                        if (illegal_s) begin
                            state_r     <= RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_exc_r   <= 1'b1;
                            rsp_data_r  <= '0;
                        end else begin
                            state_r    <= REQ;
                            mem_req_r  <= 1'b1;
                            mem_addr_r <= req_addr_i & ~XLEN'(BYTES - 1);
                            offset_r   <= req_off_s;
                            funct3_r   <= req_funct3_i;
                            two_beat_r <= two_beat_s;
                            second_r   <= 1'b0;
                        end
                    end
                end
                REQ: begin
                    if (flush_i) begin
                        state_r   <= IDLE;
                        mem_req_r <= 1'b0;
                        ready_r   <= 1'b1;
                    end else if (mem_gnt_i) begin
                        state_r   <= WAIT;
                        mem_req_r <= 1'b0;
                    end
                end
                WAIT: begin
                    // A flush coinciding with the data beat has nothing left to drain.
                    if (flush_i && mem_rvalid_i) begin
                        state_r <= IDLE;
                        ready_r <= 1'b1;
                    end else if (flush_i) begin
                        state_r <= DRAIN;
                    end else if (mem_rvalid_i) begin
                        if (two_beat_r && !second_r) begin
                            beat1_r    <= mem_rdata_i;
                            second_r   <= 1'b1;
                            mem_addr_r <= mem_addr_r + XLEN'(BYTES);
                            mem_req_r  <= 1'b1;
                            state_r    <= REQ;
                        end else begin
                            rsp_data_r  <= extract_s;
                            rsp_exc_r   <= 1'b0;
                            rsp_valid_r <= 1'b1;
                            state_r     <= RESP;
                        end
                    end
                end
                DRAIN: begin
                    if (mem_rvalid_i) begin
                        state_r <= IDLE;
                        ready_r <= 1'b1;
                    end
                end
                RESP: begin
                    state_r     <= IDLE;
                    rsp_valid_r <= 1'b0;
                    ready_r     <= 1'b1;
                end
                default: begin
                    state_r     <= IDLE;
                    mem_req_r   <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    ready_r     <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o = ready_r;
    assign mem_req_o   = mem_req_r;
    assign mem_addr_o  = mem_addr_r;
    // A flush in RESP suppresses the pending response.
    assign rsp_valid_o = rsp_valid_r & ~flush_i;
    assign rsp_data_o  = rsp_data_r;
    assign rsp_exc_o   = rsp_exc_r;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: XLEN=32 misaligned-capable and strict
// instances plus an XLEN=64 instance, checked against hand-computed values.
module tb_load_align_unit;
    import load_align_pkg::*;

    logic        clk;
    logic        rst_n;

    logic        req_valid, req_ready, flush, mem_req, mem_gnt, mem_rvalid, rsp_valid, rsp_exc;
    logic [31:0] req_addr, mem_addr, mem_rdata, rsp_data;
    logic [2:0]  req_funct3;

    logic        s_req_valid, s_req_ready, s_mem_req, s_rsp_valid, s_rsp_exc;
    logic [31:0] s_mem_addr, s_rsp_data;

    logic        w_req_valid, w_req_ready, w_flush, w_mem_req, w_mem_gnt, w_mem_rvalid, w_rsp_valid, w_rsp_exc;
    logic [63:0] w_req_addr, w_mem_addr, w_mem_rdata, w_rsp_data;
    logic [2:0]  w_req_funct3;

    int n_assert;
    int n_fail;

    load_align_unit #(.XLEN(32), .ALLOW_MISALIGNED(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_funct3_i(req_funct3),
        .flush_i(flush), .mem_req_o(mem_req), .mem_addr_o(mem_addr),
        .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_exc_o(rsp_exc)
    );

    load_align_unit #(.XLEN(32), .ALLOW_MISALIGNED(0)) u_dut_strict (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(s_req_valid), .req_ready_o(s_req_ready),
        .req_addr_i(req_addr), .req_funct3_i(req_funct3),
        .flush_i(flush), .mem_req_o(s_mem_req), .mem_addr_o(s_mem_addr),
        .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .rsp_valid_o(s_rsp_valid), .rsp_data_o(s_rsp_data), .rsp_exc_o(s_rsp_exc)
    );

    load_align_unit #(.XLEN(64), .ALLOW_MISALIGNED(1)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(w_req_valid), .req_ready_o(w_req_ready),
        .req_addr_i(w_req_addr), .req_funct3_i(w_req_funct3),
        .flush_i(w_flush), .mem_req_o(w_mem_req), .mem_addr_o(w_mem_addr),
        .mem_gnt_i(w_mem_gnt), .mem_rvalid_i(w_mem_rvalid), .mem_rdata_i(w_mem_rdata),
        .rsp_valid_o(w_rsp_valid), .rsp_data_o(w_rsp_data), .rsp_exc_o(w_rsp_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        req_valid = 1'b0; s_req_valid = 1'b0; req_addr = 32'h0; req_funct3 = 3'b000;
        flush = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        w_req_valid = 1'b0; w_req_addr = 64'h0; w_req_funct3 = 3'b000; w_flush = 1'b0;
        w_mem_gnt = 1'b0; w_mem_rvalid = 1'b0; w_mem_rdata = 64'h0;

        // Reset state
        #12;
        chk("rst_mem_req", 64'(mem_req), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_rsp_exc", 64'(rsp_exc), 64'h0);
        chk("rst_rsp_data", 64'(rsp_data), 64'h0);
        rst_n = 1'b1;
        tick();
        chk("rst_ready", 64'(req_ready), 64'h1);
        chk("rst_ready64", 64'(w_req_ready), 64'h1);

        // lb @0x1003, single beat, sign extension
        req_valid = 1'b1; req_addr = 32'h0000_1003; req_funct3 = LB;
        tick(); req_valid = 1'b0;
        chk("lb_mem_req", 64'(mem_req), 64'h1);
        chk("lb_mem_addr", 64'(mem_addr), 64'h1000);
        chk("lb_ready_busy", 64'(req_ready), 64'h0);
        mem_gnt = 1'b1;
        tick(); mem_gnt = 1'b0;
        chk("lb_req_drop", 64'(mem_req), 64'h0);
        mem_rvalid = 1'b1; mem_rdata = 32'h80FF_1234;
        tick(); mem_rvalid = 1'b0;
        chk("lb_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("lb_rsp_data", 64'(rsp_data), 64'hFFFF_FF80);
        chk("lb_rsp_exc", 64'(rsp_exc), 64'h0);
        tick();
        chk("lb_rsp_pulse", 64'(rsp_valid), 64'h0);
        chk("lb_data_hold", 64'(rsp_data), 64'hFFFF_FF80);
        chk("lb_ready_back", 64'(req_ready), 64'h1);

        // lhu @0x1003, crosses into the next word
        req_valid = 1'b1; req_addr = 32'h0000_1003; req_funct3 = LHU;
        tick(); req_valid = 1'b0;
        chk("lhu_addr1", 64'(mem_addr), 64'h1000);
        mem_gnt = 1'b1;
        tick(); mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hAB00_0000;
        tick(); mem_rvalid = 1'b0;
        chk("lhu_rsp_early", 64'(rsp_valid), 64'h0);
        chk("lhu_mem_req2", 64'(mem_req), 64'h1);
        chk("lhu_addr2", 64'(mem_addr), 64'h1004);
        mem_gnt = 1'b1;
        tick(); mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_00CD;
        tick(); mem_rvalid = 1'b0;
        chk("lhu_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("lhu_rsp_data", 64'(rsp_data), 64'h0000_CDAB);
        tick();

        // ld on XLEN=32 is illegal
        req_valid = 1'b1; req_addr = 32'h0000_1000; req_funct3 = LD;
        tick(); req_valid = 1'b0;
        chk("ld32_no_mem", 64'(mem_req), 64'h0);
        chk("ld32_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("ld32_exc", 64'(rsp_exc), 64'h1);
        chk("ld32_data", 64'(rsp_data), 64'h0);
        tick();
        chk("ld32_pulse", 64'(rsp_valid), 64'h0);

        // Strict instance: misaligned lw raises an exception
        s_req_valid = 1'b1; req_addr = 32'h0000_1002; req_funct3 = LW;
        tick(); s_req_valid = 1'b0;
        chk("strict_no_mem", 64'(s_mem_req), 64'h0);
        chk("strict_rsp_valid", 64'(s_rsp_valid), 64'h1);
        chk("strict_exc", 64'(s_rsp_exc), 64'h1);
        chk("strict_data", 64'(s_rsp_data), 64'h0);
        tick();
        chk("strict_pulse", 64'(s_rsp_valid), 64'h0);
        chk("strict_ready", 64'(s_req_ready), 64'h1);

        // lw @0xFFFFFFFE with a 3-cycle grant stall; second beat wraps to 0
        req_valid = 1'b1; req_addr = 32'hFFFF_FFFE; req_funct3 = LW;
        tick(); req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("wrap_stall_req", 64'(mem_req), 64'h1);
            chk("wrap_stall_addr", 64'(mem_addr), 64'hFFFF_FFFC);
            tick();
        end
        chk("wrap_addr_at_gnt", 64'(mem_addr), 64'hFFFF_FFFC);
        mem_gnt = 1'b1;
        tick(); mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h2211_0000;
        tick(); mem_rvalid = 1'b0;
        chk("wrap_addr2", 64'(mem_addr), 64'h0);
        mem_gnt = 1'b1;
        tick(); mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_4433;
        tick(); mem_rvalid = 1'b0;
        chk("wrap_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("wrap_rsp_data", 64'(rsp_data), 64'h4433_2211);
        tick();

        // Flush in WAIT, drain the stale beat, then a fresh lw @0x2000
        req_valid = 1'b1; req_addr = 32'h0000_1000; req_funct3 = LW;
        tick(); req_valid = 1'b0;
        mem_gnt = 1'b1;
        tick(); mem_gnt = 1'b0;
        flush = 1'b1;
        tick(); flush = 1'b0;
        chk("flush_drain_busy", 64'(req_ready), 64'h0);
        chk("flush_no_rsp", 64'(rsp_valid), 64'h0);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick(); mem_rvalid = 1'b0;
        chk("flush_discard", 64'(rsp_valid), 64'h0);
        chk("flush_idle", 64'(req_ready), 64'h1);
        chk("flush_data_kept", 64'(rsp_data), 64'h4433_2211);
        req_valid = 1'b1; req_addr = 32'h0000_2000; req_funct3 = LW;
        tick(); req_valid = 1'b0;
        chk("after_flush_addr", 64'(mem_addr), 64'h2000);
        mem_gnt = 1'b1;
        tick(); mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        tick(); mem_rvalid = 1'b0;
        chk("after_flush_valid", 64'(rsp_valid), 64'h1);
        chk("after_flush_data", 64'(rsp_data), 64'h1234_5678);
        tick();

        // Reset mid-load: no response, late rvalid ignored
        req_valid = 1'b1; req_addr = 32'h0000_3000; req_funct3 = LW;
        tick(); req_valid = 1'b0;
        mem_gnt = 1'b1;
        tick(); mem_gnt = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("midrst_mem_req", 64'(mem_req), 64'h0);
        chk("midrst_data", 64'(rsp_data), 64'h0);
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick(); mem_rvalid = 1'b0;
        chk("midrst_no_rsp", 64'(rsp_valid), 64'h0);
        chk("midrst_ready", 64'(req_ready), 64'h1);

        // XLEN=64: ld @0x0C crosses the doubleword boundary
        w_req_valid = 1'b1; w_req_addr = 64'h0C; w_req_funct3 = LD;
        tick(); w_req_valid = 1'b0;
        chk("ld64_addr1", w_mem_addr, 64'h08);
        w_mem_gnt = 1'b1;
        tick(); w_mem_gnt = 1'b0;
        w_mem_rvalid = 1'b1; w_mem_rdata = 64'h8877_6655_0000_0000;
        tick(); w_mem_rvalid = 1'b0;
        chk("ld64_addr2", w_mem_addr, 64'h10);
        w_mem_gnt = 1'b1;
        tick(); w_mem_gnt = 1'b0;
        w_mem_rvalid = 1'b1; w_mem_rdata = 64'h0000_0000_CCBB_AA99;
        tick(); w_mem_rvalid = 1'b0;
        chk("ld64_valid", 64'(w_rsp_valid), 64'h1);
        chk("ld64_data", w_rsp_data, 64'hCCBB_AA99_8877_6655);
        chk("ld64_exc", 64'(w_rsp_exc), 64'h0);
        tick();

        // XLEN=64: lw sign-extends to 64 bits
        w_req_valid = 1'b1; w_req_addr = 64'h10; w_req_funct3 = LW;
        tick(); w_req_valid = 1'b0;
        w_mem_gnt = 1'b1;
        tick(); w_mem_gnt = 1'b0;
        w_mem_rvalid = 1'b1; w_mem_rdata = 64'h0000_0000_8000_0001;
        tick(); w_mem_rvalid = 1'b0;
        chk("lw64_data", w_rsp_data, 64'hFFFF_FFFF_8000_0001);
        tick();

        // XLEN=64: funct3=3'b111 is illegal
        w_req_valid = 1'b1; w_req_addr = 64'h20; w_req_funct3 = 3'b111;
        tick(); w_req_valid = 1'b0;
        chk("f111_no_mem", 64'(w_mem_req), 64'h0);
        chk("f111_valid", 64'(w_rsp_valid), 64'h1);
        chk("f111_exc", 64'(w_rsp_exc), 64'h1);
        chk("f111_data", w_rsp_data, 64'h0);
        tick();
        chk("f111_pulse", 64'(w_rsp_valid), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/load_align_unit.md
LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the datapath width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter ALLOW_MISALIGNED, default 1; 1 = split misaligned loads into two beats, 0 = raise exception.
REQ-003 The block SHALL have ports clk (in, 1, clock) and rst_n (in, 1, reset); there is one clock, and reset is asynchronous and active-low.
REQ-004 The block SHALL have ports req_valid_i (in, 1, load request) and req_ready_o (out, 1, block can accept).
REQ-005 The block SHALL have ports req_addr_i (in, XLEN, byte address) and req_funct3_i (in, 3, load type, RISC-V encoding).
REQ-006 The block SHALL have ports flush_i (in, 1, abandon the current load), mem_req_o (out, 1) and mem_addr_o (out, XLEN, aligned to XLEN/8 bytes).
REQ-007 The block SHALL have ports mem_gnt_i (in, 1), mem_rvalid_i (in, 1) and mem_rdata_i (in, XLEN).
REQ-008 The block SHALL have ports rsp_valid_o (out, 1, pulse), rsp_data_o (out, XLEN, extended data) and rsp_exc_o (out, 1, misaligned or illegal type).

Function
REQ-009 A request SHALL be accepted when req_valid_i && req_ready_o; req_ready_o = 1 only in IDLE.
REQ-010 Access size SHALL be 2^funct3[1:0] bytes; funct3[2]=1 selects zero-extension, otherwise sign-extension.
REQ-011 funct3 values 3'b111, 3'b011 with XLEN=32, and 3'b110 with XLEN=32 SHALL be illegal: no memory access, one rsp_valid_o pulse with rsp_exc_o=1 and rsp_data_o=0.
REQ-012 offset = addr mod (XLEN/8); a load SHALL be two-beat iff offset+size > XLEN/8.
REQ-013 With ALLOW_MISALIGNED=0, any load whose address is not size-aligned SHALL respond as in REQ-011.
REQ-014 FSM states SHALL be IDLE, REQ, WAIT, RESP, DRAIN, with transitions:
- IDLE->REQ on a legal accept.
- IDLE->RESP on an illegal accept.
- REQ->WAIT on mem_gnt_i.
- WAIT->REQ on mem_rvalid_i with a second beat pending.
- WAIT->RESP on mem_rvalid_i for the final beat.
- RESP->IDLE unconditionally.
REQ-015 mem_req_o SHALL be 1 only in REQ, with mem_addr_o held stable until mem_gnt_i; at most one beat is outstanding.
REQ-016 Beat-1 address SHALL be the request address with the low log2(XLEN/8) bits cleared; beat-2 address = beat-1 + XLEN/8, wrapping modulo 2^XLEN.
REQ-017 Beat-1 data SHALL be captured in a register; the result is bytes [offset .. offset+size-1] of {beat2, beat1}, extended to XLEN.
REQ-018 rsp_valid_o SHALL be asserted for exactly one cycle in RESP with registered rsp_data_o/rsp_exc_o; best-case aligned latency is accept T, mem_req_o T+1, rvalid T+2, rsp_valid_o T+3.
REQ-019 flush_i SHALL behave by state:
- In REQ or RESP: go to IDLE with no response.
- In WAIT: go to DRAIN, discard the next mem_rvalid_i, then go to IDLE.
- In IDLE or DRAIN: ignored.
REQ-020 rsp_data_o SHALL retain its last value outside RESP; mem_rvalid_i outside WAIT/DRAIN SHALL be ignored.

Reset
REQ-021 On rst_n=0, the FSM SHALL go to IDLE asynchronously and all registers clear: mem_req_o=0, rsp_valid_o=0, rsp_exc_o=0, rsp_data_o=0, req_ready_o=1 after release.
REQ-022 Reset mid-operation SHALL abandon the load without a response; any memory response arriving after release is ignored per REQ-020.

Structure
REQ-023 Package load_align_pkg SHALL hold the FSM state enum, funct3 localparams (LB, LH, LW, LD, LBU, LHU, LWU) and a size-from-funct3 function.
REQ-024 Byte selection and extension SHALL live in the combinational sub-module load_extract (params XLEN; inputs 2*XLEN data, offset, funct3; output XLEN).

Verification
REQ-025 The bench SHALL cover: XLEN=32, lb @0x1003, word@0x1000=0x80FF1234 -> one mem_req at 0x1000, rsp_data_o=0xFFFFFF80, rsp_exc_o=0.
REQ-026 The bench SHALL cover: lhu @0x1003, word@0x1000=0xAB000000, word@0x1004=0x000000CD -> mem_addr 0x1000 then 0x1004, rsp_data_o=0x0000CDAB.
REQ-027 The bench SHALL cover: ALLOW_MISALIGNED=0, lw @0x1002 -> no mem_req_o, rsp_valid_o one cycle, rsp_exc_o=1, rsp_data_o=0.
REQ-028 The bench SHALL cover: lw @0xFFFFFFFE, mem_gnt_i delayed 3 cycles -> mem_addr_o stable at 0xFFFFFFFC during the stall, second beat at 0x00000000.
REQ-029 The bench SHALL cover: flush_i in WAIT, then new lw @0x2000 -> the first rvalid is discarded, no rsp for the flushed load, the new load returns the correct word.
REQ-030 The bench SHALL cover: XLEN=64, ld @0x0C (crossing) and funct3=3'b111 -> correct 64-bit merge, and exception respectively.
